// File: rtl/rand_pkg.sv
// Shared definitions for the LFSR random-number server.
package rand_pkg;

    localparam logic [15:0] LFSR_TAPS_16  = 16'hB400;
    localparam logic [15:0] LFSR_SEED_DEF = 16'h0001;

    typedef enum logic {
        WARM,
        SERVE
    } state_e;

    // One Fibonacci step: shift left, feedback is the parity of the tapped bits.
    // Carried in a 32-bit container so any WIDTH up to 32 can share it.
    function automatic logic [31:0] lfsr_next(input logic [31:0]   state,
                                              input logic [31:0]   taps,
                                              input int unsigned   width);
        logic [31:0] nxt;
        logic [31:0] keep;
        nxt  = {state[30:0], ^(state & taps)};
        keep = (width >= 32) ? '1 : ((32'd1 << width) - 32'd1);
        return nxt & keep;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first eligible request at or after ptr_i, wrapping.
module rr_arbiter #(
    parameter int unsigned N_REQ = 4
) (
    input  logic [N_REQ-1:0]         req_i,
    input  logic [N_REQ-1:0]         mask_i,
    input  logic [$clog2(N_REQ)-1:0] ptr_i,
    output logic [N_REQ-1:0]         gnt_o,
    output logic [$clog2(N_REQ)-1:0] idx_o,
    output logic                     valid_o
);

    localparam int unsigned IDW = $clog2(N_REQ);

    logic [N_REQ-1:0] elig;

    // Scan from the pointer and pick the first eligible requester.
    always_comb begin
        int unsigned pos;
        logic        found;
        elig    = req_i & ~mask_i;
        gnt_o   = '0;
        idx_o   = '0;
        found   = 1'b0;
        pos     = 0;
        for (int unsigned off = 0; off < N_REQ; off++) begin
            pos = (32'(ptr_i) + off) % N_REQ;
            if (!found && elig[pos]) begin
                found      = 1'b1;
                gnt_o[pos] = 1'b1;
                idx_o      = IDW'(pos);
            end
        end
        valid_o = found;
    end

endmodule

// File: rtl/rand_server.sv
// Shares one Fibonacci LFSR between N_REQ req/ack clients with round-robin arbitration,
// runtime reseeding and an optional warm-up after reset or seed load.
module rand_server
    import rand_pkg::*;
#(
    parameter int unsigned       WIDTH  = 16,
    parameter logic [WIDTH-1:0]  TAPS   = WIDTH'(LFSR_TAPS_16),
    parameter int unsigned       N_REQ  = 4,
    parameter int unsigned       WARMUP = 0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [N_REQ-1:0]         req,
    output logic [N_REQ-1:0]         ack,
    output logic [WIDTH-1:0]         rand_data,
    output logic [$clog2(N_REQ)-1:0] grant_id,
    input  logic                     seed_wr,
    input  logic [WIDTH-1:0]         seed,
    output logic                     busy
);

    localparam int unsigned IDW       = $clog2(N_REQ);
    localparam state_e      ST_INIT   = (WARMUP == 0) ? SERVE : WARM;
    localparam logic [7:0]  WARM_LAST = (WARMUP == 0) ? 8'd0 : 8'(WARMUP - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] lfsr_q, lfsr_d;
    logic [7:0]       cnt_q, cnt_d;
    logic [IDW-1:0]   ptr_q, ptr_d;
    logic [N_REQ-1:0] ack_q, ack_d;
    logic [IDW-1:0]   gid_q, gid_d;
    logic [WIDTH-1:0] data_q, data_d;

    logic [WIDTH-1:0] lfsr_step;
    logic [N_REQ-1:0] arb_gnt;
    logic [IDW-1:0]   arb_idx;
    logic             arb_valid;

    assign lfsr_step = WIDTH'(lfsr_next(32'(lfsr_q), 32'(TAPS), WIDTH));

    // A core acked this cycle still holds req, so it is masked out of this arbitration.
    rr_arbiter #(
        .N_REQ (N_REQ)
    ) u_arb (
        .req_i   (req),
        .mask_i  (ack_q),
        .ptr_i   (ptr_q),
        .gnt_o   (arb_gnt),
        .idx_o   (arb_idx),
        .valid_o (arb_valid)
    );

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_INIT;
            lfsr_q  <= WIDTH'(LFSR_SEED_DEF);
            cnt_q   <= '0;
            ptr_q   <= '0;
            ack_q   <= '0;
            gid_q   <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            lfsr_q  <= lfsr_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            ack_q   <= ack_d;
            gid_q   <= gid_d;
            data_q  <= data_d;
        end
    end

    // Next state: seed load overrides everything and cancels the pending grant.
    always_comb begin
        state_d = state_q;
        lfsr_d  = lfsr_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        ack_d   = '0;
        gid_d   = gid_q;
        data_d  = data_q;
        if (seed_wr) begin
            lfsr_d  = (seed == '0) ? WIDTH'(LFSR_SEED_DEF) : seed;
            cnt_d   = '0;
            state_d = ST_INIT;
        end else begin
            case (state_q)
                WARM: begin
                    lfsr_d = lfsr_step;
                    cnt_d  = cnt_q + 8'd1;
                    if (cnt_q == WARM_LAST) begin
                        state_d = SERVE;
                    end
                end
                SERVE: begin
                    if (arb_valid) begin
                        ack_d  = arb_gnt;
                        gid_d  = arb_idx;
                        data_d = lfsr_q;
                        lfsr_d = lfsr_step;
                        ptr_d  = (arb_idx == IDW'(N_REQ - 1)) ? '0 : arb_idx + 1'b1;
                    end
                end
                default: state_d = ST_INIT;
            endcase
        end
    end

    assign ack       = ack_q;
    assign grant_id  = gid_q;
    assign rand_data = data_q;
    assign busy      = (state_q == WARM);

endmodule

// File: tb/tb_rand_server.sv
// Scoreboard bench for rand_server: two instances (no warm-up and WARMUP=3).
module tb_rand_server;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    // Instance 0: WARMUP = 0
    logic        rst0 = 1'b1;
    logic [3:0]  req0 = '0;
    logic [3:0]  ack0;
    logic [15:0] rand0;
    logic [1:0]  gid0;
    logic        swr0 = 1'b0;
    logic [15:0] seed0 = '0;
    logic        busy0;

    // Instance 1: WARMUP = 3
    logic        rstw = 1'b1;
    logic [3:0]  reqw = '0;
    logic [3:0]  ackw;
    logic [15:0] randw;
    logic [1:0]  gidw;
    logic        swrw = 1'b0;
    logic [15:0] seedw = '0;
    logic        busyw;

    int n_cmp = 0;
    int n_bad = 0;

    logic [17:0] q0[$];
    logic [17:0] qw[$];

    rand_server #(.WIDTH(16), .TAPS(16'hB400), .N_REQ(4), .WARMUP(0)) dut0 (
        .clk(clk), .reset(rst0), .req(req0), .ack(ack0), .rand_data(rand0),
        .grant_id(gid0), .seed_wr(swr0), .seed(seed0), .busy(busy0)
    );

    rand_server #(.WIDTH(16), .TAPS(16'hB400), .N_REQ(4), .WARMUP(3)) dutw (
        .clk(clk), .reset(rstw), .req(reqw), .ack(ackw), .rand_data(randw),
        .grant_id(gidw), .seed_wr(swrw), .seed(seedw), .busy(busyw)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h required %h", nm, act, exp);
        end
    endtask

    task automatic tmo(input string nm);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: no ack within cycle budget, required an ack", nm);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitors: every ack pops the oldest expectation {grant_id, rand_data}.
    always @(negedge clk) begin
        if (|ack0) begin
            chk("dut0_ack_onehot", 32'($countones(ack0)), 32'd1);
            if (q0.size() == 0) begin
                chk("dut0_unexpected_ack", {14'd0, gid0, rand0}, 32'h3FFFF);
            end else begin
                logic [17:0] e;
                e = q0.pop_front();
                chk("dut0_grant_id", 32'(gid0), 32'(e[17:16]));
                chk("dut0_rand_data", 32'(rand0), 32'(e[15:0]));
                chk("dut0_ack_bit", 32'(ack0[e[17:16]]), 32'd1);
            end
        end
    end

    always @(negedge clk) begin
        if (|ackw) begin
            if (qw.size() == 0) begin
                chk("dutw_unexpected_ack", {14'd0, gidw, randw}, 32'h3FFFF);
            end else begin
                logic [17:0] e;
                e = qw.pop_front();
                chk("dutw_grant_id", 32'(gidw), 32'(e[17:16]));
                chk("dutw_rand_data", 32'(randw), 32'(e[15:0]));
            end
        end
    end

    // Request one word for a core on dut0 and hold req until its ack is seen.
    task automatic serve(input int core, input logic [15:0] exp);
        bit ok;
        ok = 1'b0;
        q0.push_back({2'(core), exp});
        req0[core] = 1'b1;
        for (int i = 0; i < 20 && !ok; i++) begin
            tick();
            if (ack0[core]) ok = 1'b1;
        end
        req0[core] = 1'b0;
        if (!ok) tmo("serve_wait");
    endtask

    task automatic reset0();
        rst0 = 1'b1;
        req0 = '0;
        swr0 = 1'b0;
        repeat (2) tick();
        rst0 = 1'b0;
    endtask

    logic [15:0] serial_words [14] = '{
        16'h0001, 16'h0002, 16'h0004, 16'h0008, 16'h0010, 16'h0020, 16'h0040,
        16'h0080, 16'h0100, 16'h0200, 16'h0400, 16'h0801, 16'h1002, 16'h2005
    };
    int          rr_ids   [5] = '{0, 1, 2, 3, 0};
    logic [15:0] rr_words [5] = '{16'h0001, 16'h0002, 16'h0004, 16'h0008, 16'h0010};

    initial begin
        int cnt;
        bit ok;

        // Reset values
        repeat (3) tick();
        chk("rst_ack", 32'(ack0), 32'd0);
        chk("rst_rand_data", 32'(rand0), 32'd0);
        chk("rst_grant_id", 32'(gid0), 32'd0);
        chk("rst_busy", 32'(busy0), 32'd0);
        rst0 = 1'b0;

        // One requester, serial grants walk the LFSR sequence
        for (int i = 0; i < 14; i++) serve(0, serial_words[i]);

        // All cores requesting: rotation core0..3,0
        reset0();
        for (int i = 0; i < 5; i++) q0.push_back({2'(rr_ids[i]), rr_words[i]});
        req0 = 4'b1111;
        cnt  = 0;
        for (int i = 0; i < 20 && cnt < 5; i++) begin
            tick();
            if (|ack0) cnt++;
        end
        req0 = '0;
        chk("rr_grant_count", 32'(cnt), 32'd5);

        // Held request from a just-acked core is not granted on consecutive cycles
        reset0();
        q0.push_back({2'd3, 16'h0001});
        q0.push_back({2'd3, 16'h0002});
        req0 = 4'b1000;
        cnt  = 0;
        repeat (4) begin
            tick();
            if (ack0[3]) cnt++;
        end
        req0 = '0;
        chk("mask_grant_count", 32'(cnt), 32'd2);

        // Seed of zero is replaced by 0001 and cancels the pending grant
        serve(0, 16'h0004);
        q0.push_back({2'd2, 16'h0001});
        req0[2] = 1'b1;
        swr0    = 1'b1;
        seed0   = 16'h0000;
        tick();
        swr0 = 1'b0;
        chk("seed_cancel_ack", 32'(ack0), 32'd0);
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            if (ack0[2]) ok = 1'b1;
            else tick();
        end
        req0[2] = 1'b0;
        if (!ok) tmo("seed0_wait");

        // Seed ACE1 and the following step
        tick();
        swr0  = 1'b1;
        seed0 = 16'hACE1;
        tick();
        swr0 = 1'b0;
        chk("seed_ace1_noack", 32'(ack0), 32'd0);
        serve(1, 16'hACE1);
        serve(1, 16'h59C3);

        // Reset mid-operation drops the in-flight grant and clears outputs
        rst0 = 1'b1;
        req0 = 4'b0010;
        tick();
        chk("midrst_ack", 32'(ack0), 32'd0);
        chk("midrst_rand_data", 32'(rand0), 32'd0);
        chk("midrst_grant_id", 32'(gid0), 32'd0);
        rst0 = 1'b0;
        req0 = '0;
        serve(0, 16'h0001);

        // WARMUP=3: three busy cycles, request ignored, first word 0008
        rstw = 1'b1;
        reqw = 4'b0001;
        qw.push_back({2'd0, 16'h0008});
        repeat (2) tick();
        rstw = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("warm_busy", 32'(busyw), 32'd1);
            chk("warm_no_ack", 32'(ackw), 32'd0);
        end
        @(negedge clk);
        chk("warm_done_busy", 32'(busyw), 32'd0);
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            tick();
            if (ackw[0]) ok = 1'b1;
        end
        reqw = '0;
        if (!ok) tmo("warm_wait");

        // Seed mid warm-up restarts the count from the new seed: 0010 -> 0080
        rstw = 1'b1;
        reqw = 4'b0001;
        qw.push_back({2'd0, 16'h0080});
        repeat (2) tick();
        rstw = 1'b0;
        tick();
        swrw  = 1'b1;
        seedw = 16'h0010;
        tick();
        swrw = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("reseed_busy", 32'(busyw), 32'd1);
            chk("reseed_no_ack", 32'(ackw), 32'd0);
        end
        @(negedge clk);
        chk("reseed_done_busy", 32'(busyw), 32'd0);
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            tick();
            if (ackw[0]) ok = 1'b1;
        end
        reqw = '0;
        if (!ok) tmo("reseed_wait");

        repeat (3) tick();
        chk("dut0_queue_drained", 32'(q0.size()), 32'd0);
        chk("dutw_queue_drained", 32'(qw.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
